seg_display_scan: RTL and testbench

//  Downstream consumer of the stopwatch counter's four BCD digits (min_l, min_r, sec_l, sec_r).

---
 rtl/seg_display_scan.sv | 133 +++++++++++++
 tb/tb_seg_display_scan.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Time-multiplexes four BCD digits onto a 4-digit common-anode 7-segment
//   display. Each digit slot begins with a short dead time in which all
//   anodes are off. The digit being adjusted blinks, and dp is lit as the
//   min/sec separator. The four inputs are captured once per frame, so a
//   counter update in the middle of a scan cannot mix old and new digits.
//
// Ports
//   clk      in   1  system clock
//   rst_n    in   1  asynchronous active-low reset
//   min_l    in   5  minutes tens   (0-9 shown, >9 blank)
//   min_r    in   5  minutes ones
//   sec_l    in   5  seconds tens
//   sec_r    in   5  seconds ones
//   adj_en   in   1  adjust mode
//   adj_sel  in   3  adjusted digit: 0=min_l 1=min_r 2=sec_l 3=sec_r, 4-7 none
//   an       out  4  anodes, active-low (an[3]=min_l .. an[0]=sec_r)
//   seg      out  7  cathodes, active-low {g,f,e,d,c,b,a}
//   dp       out  1  decimal point, active-low
module seg_display_scan #(
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD        = 2,
  parameter int BLINK_DIV   = 25000000,
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] min_l,
  input  logic [4:0] min_r,
  input  logic [4:0] sec_l,
  input  logic [4:0] sec_r,
  input  logic       adj_en,
  input  logic [2:0] adj_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  function automatic logic [6:0] decode(input logic [4:0] v);
    case (v)
      5'd0:    decode = 7'h40;
      5'd1:    decode = 7'h79;
      5'd2:    decode = 7'h24;
      5'd3:    decode = 7'h30;
      5'd4:    decode = 7'h19;
      5'd5:    decode = 7'h12;
      5'd6:    decode = 7'h02;
      5'd7:    decode = 7'h78;
      5'd8:    decode = 7'h00;
      5'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  // shd[0]=sec_r, shd[1]=sec_l, shd[2]=min_r, shd[3]=min_l (indexed by idx)
  logic [3:0][4:0]   shd_q, shd_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              slot_end, in_dead, blank;
  logic [4:0]        cur;

  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt_q < CW'(DEAD));
    end
  endgenerate

  assign slot_end = (cnt_q == CW'(SCAN_DIV - 1));
  assign cur      = shd_q[idx_q];

  always_comb begin
    cnt_d       = slot_end ? '0 : cnt_q + CW'(1);
    idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
    // Capture only on the 3->0 wrap so a whole frame shows one coherent time.
    shd_d       = (slot_end && idx_q == 2'd3) ? {min_l, min_r, sec_l, sec_r} : shd_q;
    blink_cnt_d = (blink_cnt_q == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + BW'(1);
    blink_ph_d  = (blink_cnt_q == BW'(BLINK_DIV - 1)) ? ~blink_ph_q : blink_ph_q;

    // adj_sel numbers digits from min_l, idx from sec_r: 3-idx == ~idx.
    // adj_sel 4-7 has bit 2 set and so never matches.
    blank = in_dead
         || (cur > 5'd9)
         || (LZ_SUPPRESS && idx_q == 2'd3 && cur == 5'd0)
         || (adj_en && blink_ph_q && adj_sel == {1'b0, ~idx_q});

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(cur);
      dp_d  = (idx_q != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      shd_q       <= '0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      shd_q       <= shd_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
module tb_seg_display_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] min_l = '0, min_r = '0, sec_l = '0, sec_r = '0;
  logic       adj_en = 1'b0;
  logic [2:0] adj_sel = '0;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc   = 0;   // posedges since reset release

  always #5 clk = ~clk;

  seg_display_scan #(.SCAN_DIV(8), .DEAD(2), .BLINK_DIV(64), .LZ_SUPPRESS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .adj_en(adj_en), .adj_sel(adj_sel), .an(an), .seg(seg), .dp(dp));

  seg_display_scan #(.SCAN_DIV(8), .DEAD(2), .BLINK_DIV(64), .LZ_SUPPRESS(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .adj_en(adj_en), .adj_sel(adj_sel), .an(an2), .seg(seg2), .dp(dp2));

  typedef struct {
    logic [4:0] ml, mr, sl, sr;
    logic       ae;
    logic [2:0] as;
    logic [6:0] s0, s1, s2, s3;
    logic [3:0] bm;   // slots blanked by an out-of-range digit
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, ncyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
    chk("an_onehot", ($countones(~an) > 1) ? 1 : 0, 0);
    chk("an2_onehot", ($countones(~an2) > 1) ? 1 : 0, 0);
  endtask

  task automatic chk_blank(input string name);
    chk({name, "_an"}, an, 4'hF);
    chk({name, "_seg"}, seg, 7'h7F);
    chk({name, "_dp"}, dp, 1);
    chk({name, "_an2"}, an2, 4'hF);
    chk({name, "_seg2"}, seg2, 7'h7F);
    chk({name, "_dp2"}, dp2, 1);
  endtask

  // One 8-cycle slot. lzb marks a slot that only the leading-zero unit blanks.
  task automatic check_slot(input int i, input logic [6:0] s, input logic blk, input logic lzb);
    logic bl, b1, b2;
    for (int c = 0; c < 8; c++) begin
      step();
      // output after edge k reflects blink phase after k-1 edges
      bl = adj_en && ((((ncyc - 1) / 64) % 2) == 1) && (int'(adj_sel) == 3 - i);
      b1 = (c < 2) || blk || bl;
      b2 = b1 || lzb;
      chk("an",  an,  b1 ? 4'hF  : (~(4'b0001 << i) & 4'hF));
      chk("seg", seg, b1 ? 7'h7F : s);
      chk("dp",  dp,  (b1 || i != 2) ? 1 : 0);
      chk("an_lz",  an2,  b2 ? 4'hF  : (~(4'b0001 << i) & 4'hF));
      chk("seg_lz", seg2, b2 ? 7'h7F : s);
      chk("dp_lz",  dp2,  (b2 || i != 2) ? 1 : 0);
    end
  endtask

  task automatic check_frame(input logic [6:0] s0, s1, s2, s3, input logic [3:0] bm, input logic lz0);
    check_slot(0, s0, bm[0], 1'b0);
    check_slot(1, s1, bm[1], 1'b0);
    check_slot(2, s2, bm[2], 1'b0);
    check_slot(3, s3, bm[3], lz0);
  endtask

  task automatic skip_frame();
    for (int c = 0; c < 32; c++) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ncyc  = 0;
  endtask

  initial begin
    //        ml     mr      sl     sr    ae    as     s0     s1     s2     s3     bm
    vt[0] = '{5'd1, 5'd2,  5'd3, 5'd4, 1'b0, 3'd0, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000};
    vt[1] = '{5'd9, 5'd8,  5'd7, 5'd6, 1'b0, 3'd0, 7'h02, 7'h78, 7'h00, 7'h10, 4'b0000};
    vt[2] = '{5'd0, 5'd12, 5'd5, 5'd3, 1'b0, 3'd0, 7'h30, 7'h12, 7'h7F, 7'h40, 4'b0100};
    vt[3] = '{5'd5, 5'd9,  5'd0, 5'd0, 1'b0, 3'd0, 7'h40, 7'h40, 7'h10, 7'h12, 4'b0000};
    vt[4] = '{5'd1, 5'd2,  5'd3, 5'd4, 1'b1, 3'd3, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000};
    vt[5] = '{5'd1, 5'd2,  5'd3, 5'd4, 1'b1, 3'd5, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000};
    vt[6] = '{5'd1, 5'd2,  5'd3, 5'd4, 1'b1, 3'd0, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000};

    // Reset held for 5 clocks
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_blank("reset");

    // Frame 1: shadows still 0 -> "0" everywhere; LZ unit blanks min_l
    min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;
    release_reset();
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);
    // Frame 2: inputs captured at the end of frame 1
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b0);
    // Frame 3: sec_r changes mid-frame, display must not follow yet
    check_slot(0, 7'h19, 1'b0, 1'b0);
    check_slot(1, 7'h30, 1'b0, 1'b0);
    sec_r = 5'd5;
    check_slot(2, 7'h24, 1'b0, 1'b0);
    check_slot(3, 7'h79, 1'b0, 1'b0);
    // Frame 4: new sec_r visible
    check_slot(0, 7'h12, 1'b0, 1'b0);
    check_slot(1, 7'h30, 1'b0, 1'b0);
    check_slot(2, 7'h24, 1'b0, 1'b0);
    check_slot(3, 7'h79, 1'b0, 1'b0);

    // Table: apply, let one frame capture, then check two frames (covers both blink phases)
    for (int v = 0; v < 7; v++) begin
      min_l = vt[v].ml; min_r = vt[v].mr; sec_l = vt[v].sl; sec_r = vt[v].sr;
      adj_en = vt[v].ae; adj_sel = vt[v].as;
      skip_frame();
      for (int f = 0; f < 2; f++)
        check_frame(vt[v].s0, vt[v].s1, vt[v].s2, vt[v].s3, vt[v].bm, vt[v].ml == 5'd0);
    end

    // Reset pulse mid-slot (idx=2, cnt=4)
    adj_en = 1'b0;
    for (int c = 0; c < 20; c++) step();
    chk("pre_rst_an", an, 4'hB);
    chk("pre_rst_seg", seg, 7'h24);
    #2;
    rst_n = 1'b0;
    #1;
    chk_blank("async_rst");
    repeat (2) @(posedge clk);
    #1;
    chk_blank("rst_hold");
    release_reset();
    // Scan restarts at idx 0 with zeroed shadows
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout at cyc %0d", ncyc);
    $fatal(1, "timeout");
  end

endmodule
